// File: rtl/plic_irq_arbiter.sv
// plic_irq_arbiter
// Merges NUM_SOURCES external interrupt lines with the CLINT software and
// timer requests into one registered core interrupt. Each external line
// passes through a level/edge gateway into a pending bit. Per-source
// priority, per-source enable and a global threshold select the winner.
// A PLIC-style claim/complete handshake tracks in-flight IDs.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   clint_timer_irq_i     - level MTIP request
//   clint_software_irq_i  - level MSIP request
//   plic_irq_sources_i    - external source lines (synchronous to clk)
//   cfg_en/we/addr/wdata  - register access; cfg_ready/cfg_rdata answer one cycle later
//   irq_o, irq_cause_o    - merged request and its cause (11 ext, 3 sw, 7 timer)
//   irq_extra_o           - winning external ID when the cause is external
//   irq_ack_i             - core claims the presented external ID
//   irq_complete_i        - core completes the last claimed ID
module plic_irq_arbiter #(
  parameter int unsigned NUM_SOURCES = 16,
  parameter int unsigned PRIO_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clint_timer_irq_i,
  input  logic                   clint_software_irq_i,
  input  logic [NUM_SOURCES-1:0] plic_irq_sources_i,
  input  logic                   cfg_en,
  input  logic                   cfg_we,
  input  logic [31:0]            cfg_addr,
  input  logic [31:0]            cfg_wdata,
  output logic [31:0]            cfg_rdata,
  output logic                   cfg_ready,
  output logic                   irq_o,
  output logic [4:0]             irq_cause_o,
  output logic [31:0]            irq_extra_o,
  input  logic                   irq_ack_i,
  input  logic                   irq_complete_i
);

  localparam int unsigned ID_W = 5;

  typedef enum logic [4:0] {
    CAUSE_NONE = 5'd0,
    CAUSE_SW   = 5'd3,
    CAUSE_TMR  = 5'd7,
    CAUSE_EXT  = 5'd11
  } cause_e;

  localparam logic [15:0] OFF_PENDING = 16'h1000;
  localparam logic [15:0] OFF_ENABLE  = 16'h2000;
  localparam logic [15:0] OFF_MODE    = 16'h2004;
  localparam logic [15:0] OFF_THRESH  = 16'h3000;
  localparam logic [15:0] OFF_CLAIM   = 16'h3004;

  // ID 0 is reserved: its gateway never sets pending.
  localparam logic [NUM_SOURCES-1:0] SRC_ID_MASK = {{(NUM_SOURCES-1){1'b1}}, 1'b0};

  logic [PRIO_W-1:0]      prio_q [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] enable_q;
  logic [NUM_SOURCES-1:0] mode_q;
  logic [NUM_SOURCES-1:0] pending_q;
  logic [NUM_SOURCES-1:0] in_flight_q;
  logic [NUM_SOURCES-1:0] src_q;
  logic [PRIO_W-1:0]      threshold_q;
  logic [ID_W-1:0]        claimed_id_q;

  logic [15:0]            off;
  logic [15:0]            unused_addr_hi;
  logic                   rd_acc;
  logic                   wr_acc;
  logic                   prio_slot;
  logic [ID_W-1:0]        prio_idx;

  logic                   ext_active;
  logic [ID_W-1:0]        cur_id;
  logic                   cur_ok;
  logic                   claim_rd;
  logic                   claim_go;
  logic [NUM_SOURCES-1:0] claim_mask;
  logic [NUM_SOURCES-1:0] complete_mask;
  logic [NUM_SOURCES-1:0] gw_set;
  logic [NUM_SOURCES-1:0] pending_d;
  logic [NUM_SOURCES-1:0] in_flight_d;

  logic                   best_valid;
  logic [PRIO_W-1:0]      best_prio;
  logic [ID_W-1:0]        best_id;

  logic                   irq_d;
  cause_e                 cause_d;
  logic [31:0]            extra_d;
  logic [31:0]            rdata_d;

  assign off            = cfg_addr[15:0];
  assign unused_addr_hi = cfg_addr[31:16];
  assign rd_acc         = cfg_en && !cfg_we;
  assign wr_acc         = cfg_en && cfg_we;
  assign prio_slot      = (off[15:7] == '0) && (off[1:0] == 2'b00);
  assign prio_idx       = off[6:2];

  // Claims act on the registered winner, so an ack and a cfg claim read in
  // the same cycle resolve to a single ID.
  assign ext_active = irq_o && (irq_cause_o == CAUSE_EXT);
  assign cur_id     = irq_extra_o[ID_W-1:0];
  assign claim_rd   = rd_acc && (off == OFF_CLAIM);
  assign claim_go   = ext_active && cur_ok && (irq_ack_i || claim_rd);

  always_comb begin
    cur_ok = 1'b0;
    for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
      if (cur_id == ID_W'(i)) begin
        cur_ok = pending_q[i] && !in_flight_q[i];
      end
    end
  end

  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      claim_mask[i]    = claim_go && (cur_id == ID_W'(i));
      complete_mask[i] = (irq_complete_i && (claimed_id_q == ID_W'(i))) ||
                         (wr_acc && (off == OFF_CLAIM) && (cfg_wdata == 32'(i)));
    end
  end

  // Edge sources latch into pending even while in flight (depth one).
  assign gw_set = ((plic_irq_sources_i & ~mode_q & ~in_flight_q) |
                   (plic_irq_sources_i & ~src_q & mode_q)) & SRC_ID_MASK;

  // Claim wins over a same-cycle gateway set; a claim also wins over a
  // same-cycle completion of the same ID.
  assign pending_d   = (pending_q | gw_set) & ~claim_mask;
  assign in_flight_d = (in_flight_q & ~complete_mask) | claim_mask;

  // Arbitration excludes the ID being claimed this cycle so irq_o drops with
  // the claim, and in-flight IDs so a re-latched edge waits for completion.
  always_comb begin
    best_valid = 1'b0;
    best_prio  = '0;
    best_id    = '0;
    for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
      if (pending_q[i] && !claim_mask[i] && enable_q[i] && !in_flight_q[i] &&
          (prio_q[i] > threshold_q) && (!best_valid || (prio_q[i] > best_prio))) begin
        best_valid = 1'b1;
        best_prio  = prio_q[i];
        best_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    irq_d   = 1'b0;
    cause_d = CAUSE_NONE;
    extra_d = '0;
    if (best_valid) begin
      irq_d   = 1'b1;
      cause_d = CAUSE_EXT;
      extra_d = 32'(best_id);
    end else if (clint_software_irq_i) begin
      irq_d   = 1'b1;
      cause_d = CAUSE_SW;
    end else if (clint_timer_irq_i) begin
      irq_d   = 1'b1;
      cause_d = CAUSE_TMR;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      if (prio_slot) begin
        for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
          if (prio_idx == ID_W'(i)) begin
            rdata_d = 32'(prio_q[i]);
          end
        end
      end else begin
        case (off)
          OFF_PENDING: rdata_d = 32'(pending_q);
          OFF_ENABLE:  rdata_d = 32'(enable_q);
          OFF_MODE:    rdata_d = 32'(mode_q);
          OFF_THRESH:  rdata_d = 32'(threshold_q);
          OFF_CLAIM:   rdata_d = claim_go ? 32'(cur_id) : '0;
          default:     rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        prio_q[i] <= '0;
      end
      enable_q     <= '0;
      mode_q       <= '0;
      pending_q    <= '0;
      in_flight_q  <= '0;
      src_q        <= '0;
      threshold_q  <= '0;
      claimed_id_q <= '0;
      irq_o        <= 1'b0;
      irq_cause_o  <= '0;
      irq_extra_o  <= '0;
      cfg_ready    <= 1'b0;
      cfg_rdata    <= '0;
    end else begin
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
      src_q       <= plic_irq_sources_i;
      if (claim_go) begin
        claimed_id_q <= cur_id;
      end
      if (wr_acc) begin
        if (prio_slot) begin
          for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
            if (prio_idx == ID_W'(i)) begin
              prio_q[i] <= cfg_wdata[PRIO_W-1:0];
            end
          end
        end else begin
          case (off)
            OFF_ENABLE: enable_q    <= cfg_wdata[NUM_SOURCES-1:0];
            OFF_MODE:   mode_q      <= cfg_wdata[NUM_SOURCES-1:0];
            OFF_THRESH: threshold_q <= cfg_wdata[PRIO_W-1:0];
            default:    ;
          endcase
        end
      end
      irq_o       <= irq_d;
      irq_cause_o <= cause_d;
      irq_extra_o <= extra_d;
      cfg_ready   <= cfg_en;
      cfg_rdata   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_plic_irq_arbiter.sv
// Self-checking bench for plic_irq_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_plic_irq_arbiter;

  localparam int NS = 16;
  localparam int PW = 3;

  localparam logic [31:0] A_PEND  = 32'h1000;
  localparam logic [31:0] A_EN    = 32'h2000;
  localparam logic [31:0] A_MODE  = 32'h2004;
  localparam logic [31:0] A_THR   = 32'h3000;
  localparam logic [31:0] A_CLAIM = 32'h3004;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tmr = 1'b0;
  logic          sw = 1'b0;
  logic [NS-1:0] src = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_we = 1'b0;
  logic [31:0]   cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic [31:0]   cfg_rdata;
  logic          cfg_ready;
  logic          irq_o;
  logic [4:0]    irq_cause_o;
  logic [31:0]   irq_extra_o;
  logic          ack = 1'b0;
  logic          cmp = 1'b0;

  int checks = 0;
  int errors = 0;

  plic_irq_arbiter #(
    .NUM_SOURCES(NS),
    .PRIO_W(PW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clint_timer_irq_i(tmr),
    .clint_software_irq_i(sw),
    .plic_irq_sources_i(src),
    .cfg_en(cfg_en),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .cfg_ready(cfg_ready),
    .irq_o(irq_o),
    .irq_cause_o(irq_cause_o),
    .irq_extra_o(irq_extra_o),
    .irq_ack_i(ack),
    .irq_complete_i(cmp)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned m_prio [NS];
  bit          m_en   [NS];
  bit          m_mode [NS];
  bit          m_pend [NS];
  bit          m_infl [NS];
  bit          m_hist [NS];
  int unsigned m_thr;
  int unsigned m_claimed;
  bit          m_irq;
  bit          m_ready;
  int unsigned m_cause;
  int unsigned m_extra;
  int unsigned m_rdata;

  function automatic logic [31:0] pack_bits(input bit v [NS]);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_prio[i] = 0; m_en[i] = 0; m_mode[i] = 0;
      m_pend[i] = 0; m_infl[i] = 0; m_hist[i] = 0;
    end
    m_thr = 0; m_claimed = 0;
    m_irq = 0; m_ready = 0; m_cause = 0; m_extra = 0; m_rdata = 0;
  endtask

  // One rising edge: decide the claim from the presented request, answer any
  // read from the old state, pick the winner among old pending IDs minus the
  // one being claimed, then apply gateway, complete and register writes.
  task automatic model_step();
    int unsigned off, cid, rv, best_p, win;
    bit rd, wr, go, setb;
    bit n_pend [NS];
    bit n_infl [NS];
    off = 32'(cfg_addr[15:0]);
    rd  = cfg_en && !cfg_we;
    wr  = cfg_en && cfg_we;
    cid = m_extra;
    go  = m_irq && (m_cause == 11) && (ack || (rd && off == 32'h3004)) &&
          (cid < NS) && m_pend[cid] && !m_infl[cid];

    rv = 0;
    if (rd) begin
      if (off < 4 * NS && off % 4 == 0) rv = m_prio[off / 4];
      else if (off == 32'h1000) rv = pack_bits(m_pend);
      else if (off == 32'h2000) rv = pack_bits(m_en);
      else if (off == 32'h2004) rv = pack_bits(m_mode);
      else if (off == 32'h3000) rv = m_thr;
      else if (off == 32'h3004) rv = go ? cid : 0;
    end

    best_p = 0; win = 0;
    for (int i = 1; i < NS; i++) begin
      if (m_pend[i] && !(go && cid == i) && m_en[i] && !m_infl[i] &&
          m_prio[i] > m_thr && m_prio[i] > best_p) begin
        best_p = m_prio[i];
        win    = i;
      end
    end

    for (int i = 0; i < NS; i++) begin
      n_pend[i] = m_pend[i];
      n_infl[i] = m_infl[i];
    end
    for (int i = 1; i < NS; i++) begin
      setb = m_mode[i] ? (src[i] && !m_hist[i]) : (src[i] && !m_infl[i]);
      if (setb) n_pend[i] = 1;
      if (cmp && m_claimed == i) n_infl[i] = 0;
      if (wr && off == 32'h3004 && cfg_wdata == 32'(i)) n_infl[i] = 0;
      if (go && cid == i) begin
        n_pend[i] = 0;
        n_infl[i] = 1;
      end
    end

    if (wr) begin
      if (off < 4 * NS && off % 4 == 0) begin
        if (off != 0) m_prio[off / 4] = cfg_wdata % (1 << PW);
      end else if (off == 32'h2000) begin
        for (int i = 0; i < NS; i++) m_en[i] = cfg_wdata[i];
      end else if (off == 32'h2004) begin
        for (int i = 0; i < NS; i++) m_mode[i] = cfg_wdata[i];
      end else if (off == 32'h3000) begin
        m_thr = cfg_wdata % (1 << PW);
      end
    end

    if (win != 0) begin
      m_irq = 1; m_cause = 11; m_extra = win;
    end else if (sw) begin
      m_irq = 1; m_cause = 3; m_extra = 0;
    end else if (tmr) begin
      m_irq = 1; m_cause = 7; m_extra = 0;
    end else begin
      m_irq = 0; m_cause = 0; m_extra = 0;
    end
    if (go) m_claimed = cid;
    m_ready = cfg_en;
    m_rdata = rv;
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = n_pend[i];
      m_infl[i] = n_infl[i];
      m_hist[i] = src[i];
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk("model_irq",   32'(irq_o),       32'(m_irq));
    chk("model_cause", 32'(irq_cause_o), m_cause);
    chk("model_extra", irq_extra_o,      m_extra);
    chk("model_ready", 32'(cfg_ready),   32'(m_ready));
    chk("model_rdata", cfg_rdata,        m_rdata);
  endtask

  task automatic expect_irq(input string tag, input logic i, input logic [4:0] c,
                            input logic [31:0] x);
    chk({tag, "_irq"},   32'(irq_o),       32'(i));
    chk({tag, "_cause"}, 32'(irq_cause_o), 32'(c));
    chk({tag, "_extra"}, irq_extra_o,      x);
  endtask

  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
    cfg_en = 1; cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_en = 0; cfg_we = 0;
  endtask

  task automatic cfg_rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    cfg_en = 1; cfg_we = 0; cfg_addr = a;
    tick();
    chk(tag, cfg_rdata, exp);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    cfg_en = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    model_reset();

    // Reset state
    repeat (2) tick();
    expect_irq("reset", 1'b0, 5'd0, 32'd0);
    chk("reset_ready", 32'(cfg_ready), 32'd0);
    chk("reset_rdata", cfg_rdata, 32'd0);
    rst_n = 1;
    tick();
    cfg_rd_chk(A_PEND, 32'd0, "reset_pend");

    // 1: software request
    sw = 1; tick();
    expect_irq("sw_on", 1'b1, 5'd3, 32'd0);
    sw = 0; tick();
    expect_irq("sw_off", 1'b0, 5'd0, 32'd0);

    // 2: level source 1 claim/complete
    cfg_wr(32'h4, 32'd3);
    cfg_wr(A_EN, 32'h2);
    cfg_wr(A_THR, 32'd1);
    src = 16'h0002; tick(); tick();
    expect_irq("lvl_raise", 1'b1, 5'd11, 32'd1);
    ack = 1; tick(); ack = 0;
    expect_irq("lvl_ack", 1'b0, 5'd0, 32'd0);
    cfg_rd_chk(A_PEND, 32'd0, "lvl_pend_clr");
    repeat (3) tick();
    expect_irq("lvl_inflight", 1'b0, 5'd0, 32'd0);
    cmp = 1; tick(); cmp = 0;
    tick(); tick();
    expect_irq("lvl_reraise", 1'b1, 5'd11, 32'd1);
    src = '0; ack = 1; tick(); ack = 0;
    cmp = 1; tick(); cmp = 0;
    tick();

    // 3: priority, threshold, tie-break
    cfg_wr(32'h8,  32'd5);
    cfg_wr(32'h14, 32'd5);
    cfg_wr(32'hC,  32'd7);
    cfg_wr(A_THR, 32'd6);
    cfg_wr(A_EN, 32'h2C);
    src = 16'h002C; tick(); tick();
    expect_irq("prio_win3", 1'b1, 5'd11, 32'd3);
    cfg_wr(A_THR, 32'd7); tick();
    expect_irq("thr_mask", 1'b0, 5'd0, 32'd0);
    cfg_rd_chk(A_PEND, 32'h2C, "thr_pend_kept");
    cfg_wr(32'hC, 32'd0);
    cfg_wr(A_THR, 32'd0); tick();
    expect_irq("tie_low_id", 1'b1, 5'd11, 32'd2);
    src = '0;
    cfg_wr(A_EN, 32'h0);
    tick();

    // 4: edge mode on source 4
    cfg_wr(A_MODE, 32'h10);
    cfg_wr(32'h10, 32'd4);
    cfg_wr(A_EN, 32'h10);
    src = 16'h0010; tick(); src = '0; tick();
    expect_irq("edge_raise", 1'b1, 5'd11, 32'd4);
    cfg_rd_chk(A_CLAIM, 32'd4, "edge_claim_rd");
    src = 16'h0010; tick(); src = '0; tick();
    cfg_rd_chk(A_PEND, 32'h3C, "edge_relatch");
    expect_irq("edge_hold", 1'b0, 5'd0, 32'd0);
    src = 16'h0010; tick(); src = '0; tick();
    cfg_wr(A_CLAIM, 32'd4); tick();
    expect_irq("edge_reassert", 1'b1, 5'd11, 32'd4);
    ack = 1; tick(); ack = 0;
    cmp = 1; tick(); cmp = 0;
    repeat (3) tick();
    expect_irq("edge_third_lost", 1'b0, 5'd0, 32'd0);
    cfg_rd_chk(A_PEND, 32'h2C, "edge_pend_final");

    // 5: cause priority
    cfg_wr(A_MODE, 32'h0);
    cfg_wr(A_EN, 32'h2);
    tmr = 1; sw = 1; src = 16'h0002; tick(); tick();
    expect_irq("all_ext", 1'b1, 5'd11, 32'd1);
    src = '0; ack = 1; tick(); ack = 0;
    cmp = 1; tick(); cmp = 0;
    expect_irq("all_sw", 1'b1, 5'd3, 32'd0);
    sw = 0; tick();
    expect_irq("all_tmr", 1'b1, 5'd7, 32'd0);
    tmr = 0; tick();
    expect_irq("all_off", 1'b0, 5'd0, 32'd0);

    // 6: boundaries and reset mid-claim
    cfg_rd_chk(A_CLAIM, 32'd0, "claim_empty");
    cfg_wr(32'h0, 32'd7);
    cfg_rd_chk(32'h0, 32'd0, "prio0_slot");
    cfg_rd_chk(32'h4, 32'd3, "prio1_slot");
    cfg_rd_chk(32'h1004, 32'd0, "unmapped");
    cfg_rd_chk(32'h5A5A_2000, 32'h2, "addr_hi_ignored");
    src = 16'h0002; tick(); tick();
    expect_irq("pre_rst", 1'b1, 5'd11, 32'd1);
    ack = 1;
    #2; rst_n = 0; #1;
    expect_irq("async_rst", 1'b0, 5'd0, 32'd0);
    chk("async_rst_ready", 32'(cfg_ready), 32'd0);
    model_reset();
    ack = 0; src = '0;
    tick(); tick();
    rst_n = 1;
    repeat (3) tick();
    expect_irq("post_rst", 1'b0, 5'd0, 32'd0);
    cfg_rd_chk(A_PEND, 32'd0, "post_rst_pend");
    cfg_rd_chk(A_EN, 32'd0, "post_rst_en");

    // Randomized traffic against the model
    cfg_wr(A_EN, 32'hFFFE);
    for (int i = 1; i < NS; i++) cfg_wr(32'(4 * i), $urandom_range(0, 7));
    cfg_wr(A_THR, 32'd2);
    for (int n = 0; n < 3000; n++) begin
      src = src ^ (NS'($urandom) & NS'($urandom) & NS'($urandom));
      if ($urandom_range(0, 15) == 0) sw = ~sw;
      if ($urandom_range(0, 15) == 0) tmr = ~tmr;
      ack = ($urandom_range(0, 3) == 0);
      cmp = ($urandom_range(0, 5) == 0);
      cfg_en = ($urandom_range(0, 3) == 0);
      cfg_we = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 9))
        0, 1:    a = 32'(4 * $urandom_range(0, 17));
        2:       a = A_PEND;
        3:       a = A_EN;
        4:       a = A_MODE;
        5:       a = A_THR;
        6, 7:    a = A_CLAIM;
        8:       a = 32'h1004;
        default: a = 32'h00A5_0000 | 32'(4 * $urandom_range(1, 15));
      endcase
      if (a == A_CLAIM)     d = $urandom_range(0, 17);
      else if (a == A_MODE) d = $urandom & $urandom;
      else                  d = $urandom;
      cfg_addr = a;
      cfg_wdata = d;
      tick();
    end
    ack = 0; cmp = 0; cfg_en = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plic_irq_arbiter.md
Name: plic_irq_arbiter

Overview:
Parametrised successor to the fixed 16-source interrupt arbiter. It merges N external sources with the CLINT software and timer requests into a single core interrupt. It adds per-source priority and enable, level/edge gateway mode, a programmable threshold, and a PLIC-style claim/complete handshake over the same cfg bus. It sits between the CLINT/PLIC source wiring and the core's trap logic.

Parameters:
NUM_SOURCES, 16, number of external source lines; 2..32; ID 0 is reserved and never raises.
PRIO_W, 3, priority field width; priority 0 means never interrupt.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clint_timer_irq_i  in  1  level timer request (MTIP)
clint_software_irq_i  in  1  level software request (MSIP)
plic_irq_sources_i  in  NUM_SOURCES  external source lines, synchronous to clk
cfg_en  in  1  config access strobe
cfg_we  in  1  1 = write, 0 = read
cfg_addr  in  32  byte address; only [15:0] decoded
cfg_wdata  in  32  write data
cfg_rdata  out  32  read data, valid while cfg_ready = 1
cfg_ready  out  1  one-cycle access completion pulse
irq_o  out  1  interrupt request to the core
irq_cause_o  out  5  11 = external, 3 = software, 7 = timer
irq_extra_o  out  32  winning external ID when cause = 11, else 0
irq_ack_i  in  1  core takes the trap; claims the external ID
irq_complete_i  in  1  core finished the handler; completes the claimed ID

Behaviour:
- Reset (async, rst_n = 0): all outputs 0; priorities, enables, pending, in_flight and threshold = 0; all modes = level; edge history = 0; claimed_id = 0.
- Register map (offset = cfg_addr[15:0]):
  - 0x0000 + 4*i: priority[i], i = 1..N-1. The ID 0 slot reads 0 and ignores writes.
  - 0x1000: pending bits (read-only).
  - 0x2000: enable bits.
  - 0x2004: mode bits (1 = edge).
  - 0x3000: threshold.
  - 0x3004: claim/complete. A read claims; a write of an ID completes it.
  - Unmapped reads return 0; unmapped writes are ignored. Upper unused bits read 0.
- Cfg handshake: cfg_ready pulses high exactly one cycle after any cycle with cfg_en = 1. Reads return data captured in the cfg_en cycle. A held cfg_en produces one access per cycle.
- Gateway, per source i:
  - Level mode: pending[i] is set when the source is high and in_flight[i] = 0.
  - Edge mode: a registered 0→1 transition sets pending[i]. An edge seen while in_flight is also latched into pending (depth 1; further edges are lost).
- Arbitration:
  - Candidates are sources with pending & enable and priority > threshold.
  - The winner has the highest priority; ties go to the lowest ID.
  - The winner is registered, so ext_req and ID reflect source changes 2 cycles after the source edge (1 gateway + 1 arbiter).
- Output merge (registered):
  - irq_o = ext_req | software | timer.
  - Cause priority is external (11) > software (3) > timer (7).
  - irq_extra_o = winner ID when cause is 11, else 0.
- Claim, via irq_ack_i while irq_o = 1 and cause = 11, or via a cfg read of 0x3004:
  - Clears pending[winner], sets in_flight[winner], latches claimed_id, and returns the ID (the cfg read returns 0 if there is no winner).
  - irq_ack_i with cause 3 or 7, or with irq_o = 0, has no effect; CLINT sources are cleared at the source.
- Complete:
  - irq_complete_i clears in_flight[claimed_id].
  - A cfg write to 0x3004 clears in_flight[wdata]. Completing an ID that is not in_flight is ignored.
- Simultaneous events:
  - Claim beats gateway set in the same cycle: pending stays cleared.
  - Complete plus a still-high level source: pending re-sets on the next cycle.
  - Ack and a cfg claim in the same cycle: only one claim is performed, and the cfg read returns the same ID.
  - Priority or enable writes take effect in the arbiter on the following cycle.
  - Threshold ≥ every priority masks all external requests; pending bits are retained.
- Reset asserted mid-claim clears all state immediately. No spurious irq_o after deassertion.

Test Plan:
1. Write 1 to MSIP (software request high) → irq_o = 1, cause 3, extra 0. Drop it → irq_o = 0 within 1 cycle.
2. prio[1] = 3, enable = 0x2, threshold = 1, raise src1 (level) → irq_o = 1, cause 11, extra 1 within 2 cycles. Ack → pending[1] = 0, irq_o drops. While src1 is still high, no re-raise until complete; after complete, re-raise within 2 cycles.
3. prio[2] = 5, prio[5] = 5, prio[3] = 7 with threshold = 6, sources 2/3/5 high → winner 3. Set threshold = 7 → irq_o = 0. Set prio[3] = 0, threshold = 0 → winner 2 (tie, lowest ID).
4. Edge mode on src4: pulse, claim, pulse again while in_flight → pending[4] = 1. Complete → irq re-asserts with ID 4. A third pulse while in_flight is lost.
5. Timer, software and src1 all active → cause 11. Ack and complete with src1 low → cause 3. Clear MSIP → cause 7.
6. cfg read of 0x3004 with no winner → 0. Write to the ID 0 priority slot, then read it → 0. Assert rst_n = 0 mid-claim → all outputs 0, pending = 0.
